// File: rtl/usb_fs_pkg.sv
// USB full-speed packet constants and state encodings shared by
// the OUT and IN protocol engines.
package usb_fs_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        EP_READY,
        EP_GETTING,
        EP_STALL
    } ep_state_e;

    typedef enum logic [1:0] {
        XFR_IDLE,
        XFR_RCVD_TOKEN,
        XFR_RCVD_DATA
    } xfr_state_e;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_fs_out_ep_ctrl.sv
// Per-endpoint OUT control: endpoint FSM, read pointer,
// data toggle and setup flag.
module usb_fs_out_ep_ctrl
    import usb_fs_pkg::*;
#(
    parameter int PW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          stall_req,
    input  logic          accept,
    input  logic          accept_setup,
    input  logic [PW-1:0] accept_len,
    input  logic          get,
    output ep_state_e     state,
    output logic          toggle,
    output logic          setup,
    output logic          avail,
    output logic [PW-1:0] get_addr
);

    ep_state_e     state_next;
    logic [PW-1:0] len;
    logic          take;

    assign avail = (state == EP_GETTING) && (get_addr < len);
    assign take  = get && avail;

    always_comb begin
        state_next = state;
        unique case (state)
            EP_READY: begin
                if (stall_req) state_next = EP_STALL;
            end
            EP_GETTING: begin
                if (stall_req)
                    state_next = EP_STALL;
                else if (get_addr == len)
                    state_next = EP_READY;
            end
            EP_STALL: state_next = EP_STALL;
            default:  state_next = EP_READY;
        endcase
        if (accept) state_next = EP_GETTING;
        if (flush)  state_next = EP_READY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EP_READY;
            toggle   <= 1'b0;
            setup    <= 1'b0;
            len      <= '0;
            get_addr <= '0;
        end else begin
            state <= state_next;
            if (flush) begin
                toggle   <= 1'b0;
                setup    <= 1'b0;
                len      <= '0;
                get_addr <= '0;
            end else if (accept) begin
                // SETUP data is always DATA0, so the next one is DATA1
                toggle   <= accept_setup ? 1'b1 : ~toggle;
                setup    <= accept_setup;
                len      <= accept_len;
                get_addr <= '0;
            end else if (take) begin
                get_addr <= get_addr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/usb_fs_out_pe.sv
// USB FS OUT protocol engine: receives SETUP/OUT data into
// per-endpoint buffers and answers with ACK/NAK/STALL.
module usb_fs_out_pe
    import usb_fs_pkg::*;
#(
    parameter int NUM_OUT_EPS         = 1,
    parameter int MAX_OUT_PACKET_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_OUT_EPS-1:0] reset_ep,
    input  logic [6:0]             dev_addr,
    output logic [NUM_OUT_EPS-1:0] out_ep_data_avail,
    output logic [NUM_OUT_EPS-1:0] out_ep_setup,
    input  logic [NUM_OUT_EPS-1:0] out_ep_data_get,
    output logic [7:0]             out_ep_data,
    input  logic [NUM_OUT_EPS-1:0] out_ep_stall,
    output logic [NUM_OUT_EPS-1:0] out_ep_acked,
    input  logic                   rx_pkt_start,
    input  logic                   rx_pkt_end,
    input  logic                   rx_pkt_valid,
    input  logic [3:0]             rx_pid,
    input  logic [6:0]             rx_addr,
    input  logic [3:0]             rx_endp,
    input  logic                   rx_data_put,
    input  logic [7:0]             rx_data,
    output logic                   tx_pkt_start,
    output logic [3:0]             tx_pid,
    input  logic                   tx_pkt_end
);

    localparam int BUF_W = MAX_OUT_PACKET_SIZE + 2;
    localparam int PW    = $clog2(MAX_OUT_PACKET_SIZE + 3);
    localparam int DEPTH = NUM_OUT_EPS * BUF_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int EPW   = (NUM_OUT_EPS > 1) ? $clog2(NUM_OUT_EPS) : 1;

    xfr_state_e xfr, xfr_next;
    logic [EPW-1:0] cur_ep;
    logic           is_setup;
    logic           ovf;
    logic           tx_busy;
    logic [PW-1:0]  put_addr;
    logic [PW-1:0]  pkt_len;

    ep_state_e        ep_state [NUM_OUT_EPS];
    logic [PW-1:0]    ep_get   [NUM_OUT_EPS];
    logic [NUM_OUT_EPS-1:0] ep_toggle;
    logic [NUM_OUT_EPS-1:0] acc_vec;

    ep_state_e cur_state;
    logic      cur_toggle;
    logic      cur_flush;
    logic      token_hit;
    logic      writable;
    logic      room;
    logic      wr_en;
    logic      accept;
    logic      hs_go;
    logic [3:0] hs_pid;

    logic           rd_hit;
    logic [EPW-1:0] rd_ep;
    logic [PW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  rd_addr;

    logic [7:0] mem [DEPTH];

    assign cur_state  = ep_state[cur_ep];
    assign cur_toggle = ep_toggle[cur_ep];
    assign cur_flush  = reset_ep[cur_ep];

    // A handshake still on the wire blocks the next token
    assign token_hit = rx_pkt_end && rx_pkt_valid && !tx_busy
                    && (rx_pid == PID_OUT || rx_pid == PID_SETUP)
                    && (rx_addr == dev_addr)
                    && (int'(rx_endp) < NUM_OUT_EPS);

    assign writable = is_setup || (cur_state == EP_READY);
    assign room     = (put_addr != PW'(BUF_W));
    assign wr_en    = (xfr == XFR_RCVD_DATA) && rx_data_put
                   && room && writable && !cur_flush;
    assign pkt_len  = (put_addr >= PW'(2)) ? put_addr - PW'(2) : '0;
    assign wr_addr  = AW'(cur_ep) * AW'(BUF_W) + AW'(put_addr);
    assign rd_addr  = AW'(rd_ep) * AW'(BUF_W) + AW'(rd_ptr);

    always_comb begin
        xfr_next = xfr;
        hs_go    = 1'b0;
        hs_pid   = PID_ACK;
        accept   = 1'b0;
        unique case (xfr)
            XFR_IDLE: begin
                if (token_hit) xfr_next = XFR_RCVD_TOKEN;
            end
            XFR_RCVD_TOKEN: begin
                if (token_hit)
                    xfr_next = XFR_RCVD_TOKEN;
                else if (rx_pkt_start)
                    xfr_next = XFR_RCVD_DATA;
            end
            XFR_RCVD_DATA: begin
                if (token_hit) begin
                    xfr_next = XFR_RCVD_TOKEN;
                end else if (rx_pkt_end) begin
                    xfr_next = XFR_IDLE;
                    if (rx_pkt_valid && is_data_pid(rx_pid) && !ovf) begin
                        hs_go = 1'b1;
                        if (is_setup)
                            accept = 1'b1;
                        else if (cur_state == EP_STALL)
                            hs_pid = PID_STALL;
                        else if (cur_state == EP_GETTING)
                            hs_pid = PID_NAK;
                        else
                            accept = (rx_pid[3] == cur_toggle);
                    end
                end
            end
            default: xfr_next = XFR_IDLE;
        endcase
        if (xfr != XFR_IDLE && cur_flush) begin
            xfr_next = XFR_IDLE;
            hs_go    = 1'b0;
            accept   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xfr          <= XFR_IDLE;
            cur_ep       <= '0;
            is_setup     <= 1'b0;
            put_addr     <= '0;
            ovf          <= 1'b0;
            tx_busy      <= 1'b0;
            tx_pkt_start <= 1'b0;
            tx_pid       <= '0;
            out_ep_acked <= '0;
        end else begin
            xfr          <= xfr_next;
            tx_pkt_start <= hs_go;
            out_ep_acked <= acc_vec;
            if (hs_go) tx_pid <= hs_pid;
            if (hs_go)
                tx_busy <= 1'b1;
            else if (tx_pkt_end)
                tx_busy <= 1'b0;
            if (token_hit) begin
                cur_ep   <= EPW'(rx_endp);
                is_setup <= (rx_pid == PID_SETUP);
            end
            if (token_hit || xfr_next == XFR_IDLE) begin
                put_addr <= '0;
                ovf      <= 1'b0;
            end else if (xfr == XFR_RCVD_DATA && rx_data_put) begin
                if (room)
                    put_addr <= put_addr + PW'(1);
                else
                    ovf <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_OUT_EPS; i++) begin : g_ep
        assign acc_vec[i] = accept && (cur_ep == EPW'(i));

        usb_fs_out_ep_ctrl #(.PW(PW)) u_ctrl (
            .clk          (clk),
            .rst_n        (reset_n),
            .flush        (reset_ep[i]),
            .stall_req    (out_ep_stall[i]),
            .accept       (acc_vec[i]),
            .accept_setup (is_setup),
            .accept_len   (pkt_len),
            .get          (out_ep_data_get[i]),
            .state        (ep_state[i]),
            .toggle       (ep_toggle[i]),
            .setup        (out_ep_setup[i]),
            .avail        (out_ep_data_avail[i]),
            .get_addr     (ep_get[i])
        );
    end

    always_comb begin
        rd_hit = 1'b0;
        rd_ep  = '0;
        rd_ptr = '0;
        for (int i = 0; i < NUM_OUT_EPS; i++) begin
            if (out_ep_data_get[i] && out_ep_data_avail[i]
                && !reset_ep[i]) begin
                rd_hit = 1'b1;
                rd_ep  = EPW'(i);
                rd_ptr = ep_get[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= rx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            out_ep_data <= '0;
        else if (rd_hit)
            out_ep_data <= mem[rd_addr];
    end

endmodule
